// File: rtl/schoolbook_loader_pkg.sv
// rtl/schoolbook_loader_pkg.sv - shared constants, state encoding and width helpers for the operand loader
// Contents: default N/W/WORDS, counter-width constants, FSM state codes, clog2 helper.
package schoolbook_loader_pkg;

    // Ceiling log2; constant-foldable so it can size counters at elaboration.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // A counter for a single-word operand still needs one bit to exist.
    function automatic int cnt_width(input int value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

    localparam int DEF_N     = 256;
    localparam int DEF_W     = 32;
    localparam int DEF_WORDS = DEF_N / DEF_W;
    localparam int DEF_WCW   = cnt_width(DEF_WORDS);
    localparam int DEF_RCW   = clog2(DEF_N) + 1;

    // State encoding kept as plain constants so the register is a bare logic vector.
    localparam logic [2:0] LOAD_A  = 3'd0;
    localparam logic [2:0] LOAD_B  = 3'd1;
    localparam logic [2:0] RUN     = 3'd2;
    localparam logic [2:0] CAPTURE = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

endpackage

// File: rtl/schoolbook_operand_loader_word_shifter.sv
// rtl/schoolbook_operand_loader_word_shifter.sv - right-shifting word assembler for one N-bit operand
// Ports: clk, rst (sync, active-high), shift_en, in_data[W], q[N].
// The first word shifted in ends up in q[W-1:0], the last in q[N-1:N-W].
module schoolbook_word_shifter #(
    parameter int N = 256,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         shift_en,
    input  logic [W-1:0] in_data,
    output logic [N-1:0] q
);

    generate
        if (N > W) begin : g_multi
            always_ff @(posedge clk) begin
                if (rst) begin
                    q <= '0;
                end else if (shift_en) begin
                    q <= {in_data, q[N-1:W]};
                end
            end
        end else begin : g_single
            always_ff @(posedge clk) begin
                if (rst) begin
                    q <= '0;
                end else if (shift_en) begin
                    q <= in_data;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/schoolbook_operand_loader.sv
// rtl/schoolbook_operand_loader.sv - operand feeder and result collector for the bit-serial schoolbook multiplier
// Ports: clk, rst (sync, active-high); in_data/in_valid/in_ready word stream;
//        a_out/b_out operands and mul_rstn (active-low clear) to the multiplier, mul_c product back;
//        res_data/res_valid/res_ready result stream.
// Option: define SCHOOLBOOK_RES_REG_EN to register the product (adds a CAPTURE state, latency N+1).
module schoolbook_operand_loader
    import schoolbook_loader_pkg::*;
#(
    parameter int N = 256,
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   in_data,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [N-1:0]   a_out,
    output logic [N-1:0]   b_out,
    output logic           mul_rstn,
    input  logic [2*N-1:0] mul_c,
    output logic [2*N-1:0] res_data,
    output logic           res_valid,
    input  logic           res_ready
);

    localparam int WORDS = N / W;
    localparam int WCW   = cnt_width(WORDS);
    localparam int RCW   = clog2(N) + 1;

    generate
        if ((W < 1) || (N < W) || ((N % W) != 0)) begin : g_bad_params
            $error("schoolbook_operand_loader: N must be a non-zero multiple of W");
        end
    endgenerate

    logic [2:0]     state;
    logic [WCW-1:0] word_cnt;
    logic [RCW-1:0] run_cnt;
    logic           xfer;
    logic           last_word;
    logic           a_shift;
    logic           b_shift;

    assign in_ready  = !rst && ((state == LOAD_A) || (state == LOAD_B));
    assign res_valid = !rst && (state == DONE);
    assign xfer      = in_valid && in_ready;
    assign last_word = (word_cnt == WCW'(WORDS - 1));
    assign a_shift   = xfer && (state == LOAD_A);
    assign b_shift   = xfer && (state == LOAD_B);

    // Multiplier is held in clear while loading, so the last b transfer edge clears it
    // and it runs on the following N edges.
    always_comb begin
        mul_rstn = 1'b0;
        if (!rst) begin
            case (state)
                RUN:     mul_rstn = 1'b1;
`ifdef SCHOOLBOOK_RES_REG_EN
                CAPTURE: mul_rstn = 1'b1;
`else
                DONE:    mul_rstn = 1'b1;
`endif
                default: mul_rstn = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LOAD_A;
            word_cnt <= '0;
            run_cnt  <= '0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (xfer) begin
                        if (last_word) begin
                            word_cnt <= '0;
                            state    <= LOAD_B;
                        end else begin
                            word_cnt <= word_cnt + WCW'(1);
                        end
                    end
                end
                LOAD_B: begin
                    if (xfer) begin
                        if (last_word) begin
                            word_cnt <= '0;
                            run_cnt  <= '0;
                            state    <= RUN;
                        end else begin
                            word_cnt <= word_cnt + WCW'(1);
                        end
                    end
                end
                RUN: begin
                    // Exit on the Nth multiplier edge; the counter stops at N-1.
                    if (run_cnt == RCW'(N - 1)) begin
`ifdef SCHOOLBOOK_RES_REG_EN
                        state <= CAPTURE;
`else
                        state <= DONE;
`endif
                    end else begin
                        run_cnt <= run_cnt + RCW'(1);
                    end
                end
`ifdef SCHOOLBOOK_RES_REG_EN
                CAPTURE: begin
                    state <= DONE;
                end
`endif
                DONE: begin
                    if (res_ready) begin
                        state <= LOAD_A;
                    end
                end
                default: begin
                    state <= LOAD_A;
                end
            endcase
        end
    end

`ifdef SCHOOLBOOK_RES_REG_EN
    logic [2*N-1:0] res_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= '0;
        end else if (state == CAPTURE) begin
            res_q <= mul_c;
        end
    end

    assign res_data = res_q;
`else
    // The multiplier saturates its bit count, so mul_c holds steady throughout DONE.
    assign res_data = mul_c;
`endif

    schoolbook_word_shifter #(
        .N (N),
        .W (W)
    ) u_shift_a (
        .clk      (clk),
        .rst      (rst),
        .shift_en (a_shift),
        .in_data  (in_data),
        .q        (a_out)
    );

    schoolbook_word_shifter #(
        .N (N),
        .W (W)
    ) u_shift_b (
        .clk      (clk),
        .rst      (rst),
        .shift_en (b_shift),
        .in_data  (in_data),
        .q        (b_out)
    );

endmodule
